instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch-side controller for the 16x16 instruction memory. Drives its readEn/PC_Inc/writeEn
//  controls, captures instructWord one cycle after each read, and splits it into opcode and
//  register fields. Issues each instruction to the FP ALU datapath over a valid/ready
//  handshake. Stops on a halt word; optionally stops when the program counter wraps.
// PARAMETERS
//  ADDR_W        4       memory address width; shadow PC width; depth = 2**ADDR_W
//  HALT_WORD     16'hFFFF instruction word that ends execution (equals memory reset output)
//  STOP_ON_WRAP  1       1: enter HALT after issuing word at address 2**ADDR_W-1; 0: wrap to 0
// PORTS
//  Clock         in   1       rising-edge clock
//  Reset         in   1       synchronous, active-high; same net as instruction memory Reset
//  start         in   1       pulse: begin fetching from address 0 (ignored unless IDLE/HALT)
//  instructWord  in   16      registered word from instruction memory
//  readEn        out  1       memory read strobe
//  PC_Inc        out  1       memory PC increment strobe
//  writeEn       out  1       memory write strobe; constant 0
//  instr_valid   out  1       opcode/rd/rs/rt hold a valid instruction
//  alu_ready     in   1       datapath accepts the instruction when high with instr_valid
//  opcode        out  4       instr[15:12]
//  rd            out  4       instr[11:8]
//  rs            out  4       instr[7:4]
//  rt            out  4       instr[3:0]
//  pc_shadow     out  ADDR_W  address of the instruction currently held
//  busy          out  1       high in every state except IDLE and HALT
//  halted        out  1       high in HALT
// BEHAVIOUR
//  Reset: state=IDLE; readEn=PC_Inc=writeEn=instr_valid=busy=halted=0; opcode/rd/rs/rt=0;
//   pc_shadow=0. Reset wins over all inputs, mid-fetch or mid-handshake; nothing issued after.
//  Memory timing: readEn in cycle N -> instructWord valid in N+1; PC_Inc in N -> memory PC+1
//   from N+1. readEn and PC_Inc are never both high in the same cycle.
//  FSM (one state per cycle unless stalled):
//   IDLE    : start=1 -> FETCH; pc_shadow<=0.
//   FETCH   : readEn=1 -> CAPTURE.
//   CAPTURE : latch instructWord into fields. Word==HALT_WORD -> HALT, PC_Inc=0, no issue.
//             Else PC_Inc=1, instr_valid<=1 -> ISSUE.
//   ISSUE   : hold fields stable while alu_ready=0 (stall, no strobes).
//             alu_ready=1: instr_valid<=0; if STOP_ON_WRAP && pc_shadow==2**ADDR_W-1 -> HALT,
//             else pc_shadow<=pc_shadow+1 (mod 2**ADDR_W) -> FETCH.
//   HALT    : halted=1, all strobes 0. start=1 -> FETCH with pc_shadow<=0; caller must
//             Reset memory first (controller cannot rewind memory PC).
//  Throughput: 3 cycles/instruction with alu_ready tied high. Fields change only in CAPTURE.
//  start while busy ignored. alu_ready outside ISSUE ignored.
//  pc_shadow tracks memory PC exactly; the wrap case is the 4-bit roll-over 15->0.
// CONFIGURATION
//  FETCH_STALL_CNT_EN defined: extra output stall_cnt[15:0] counts ISSUE cycles with
//   alu_ready=0; saturates at 16'hFFFF; cleared by Reset and by accepted start.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset 3 cycles, then start; mem[0]=16'h1234, alu_ready=1 -> readEn cycle 1, instr_valid
//    cycle 3 with opcode=1 rd=2 rs=3 rt=4 pc_shadow=0; PC_Inc high exactly once.
//  2 mem[0..2]=16'h1111,16'h2222,16'hFFFF -> two issues 3 cycles apart, then halted=1,
//    busy=0, no PC_Inc for halt word, no further readEn.
//  3 mem[1]=16'hA5C3, alu_ready low 5 cycles in ISSUE -> fields stable, no strobes; with
//    FETCH_STALL_CNT_EN stall_cnt advances by 5; accept on 6th cycle.
//  4 All 16 words non-halt, STOP_ON_WRAP=1 -> 16 issues, halted after pc_shadow=15;
//    STOP_ON_WRAP=0 -> 17th issue returns mem[0] with pc_shadow=0.
//  5 Reset asserted in ISSUE with instr_valid=1 -> next cycle all outputs at reset values;
//    start pulse during busy -> no effect on sequence or pc_shadow.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Fetch-side controller for the 16x16 instruction memory: strobes reads/increments,
// decodes each word and issues it over valid/ready. Optional stall counter: FETCH_STALL_CNT_EN.
module instr_fetch_ctrl #(
  parameter int          ADDR_W       = 4,
  parameter logic [15:0] HALT_WORD    = 16'hFFFF,
  parameter bit          STOP_ON_WRAP = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic [15:0]       instructWord,
  output logic              readEn,
  output logic              PC_Inc,
  output logic              writeEn,
  output logic              instr_valid,
  input  logic              alu_ready,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [ADDR_W-1:0] pc_shadow,
  output logic              busy,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_ISSUE, S_HALT
  } state_e;

  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  state_e            state_q, state_d;
  logic [15:0]       word_q, word_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              start_acc;

  assign start_acc = start && (state_q == S_IDLE || state_q == S_HALT);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    readEn  = 1'b0;
    PC_Inc  = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        // Restart from HALT assumes memory was Reset externally; its PC cannot be rewound here.
        if (start_acc) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        readEn  = 1'b1;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        word_d = instructWord;
        if (instructWord == HALT_WORD) begin
          state_d = S_HALT;
        end else begin
          PC_Inc  = 1'b1;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (alu_ready) begin
          valid_d = 1'b0;
          if (STOP_ON_WRAP && pc_q == PC_LAST) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign opcode      = word_q[15:12];
  assign rd          = word_q[11:8];
  assign rs          = word_q[7:4];
  assign rt          = word_q[3:0];
  assign instr_valid = valid_q;
  assign pc_shadow   = pc_q;
  assign writeEn     = 1'b0;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stall_d = stall_q;
    if (start_acc)
      stall_d = '0;
    else if (state_q == S_ISSUE && !alu_ready)
      stall_d = sat_inc16(stall_q);
  end

  always_ff @(posedge Clock) begin
    if (Reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: two instances (stop-on-wrap and wrap-around) driven by an
// instruction-memory model; a scoreboard compares every accepted issue against a program model.
module tb_instr_fetch_ctrl;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic [1:0]      start_s = '0;
  logic [1:0]      rdy = '0;
  logic [1:0][15:0] iw;
  logic [1:0]      re, pi, we, iv, busy, halted;
  logic [1:0][3:0] opf, rdf, rsf, rtf, pc;
`ifdef FETCH_STALL_CNT_EN
  logic [1:0][15:0] stall;
`endif

  always #5 Clock = ~Clock;

  instr_fetch_ctrl #(.ADDR_W(4), .HALT_WORD(16'hFFFF), .STOP_ON_WRAP(1'b1)) u0 (
    .Clock(Clock), .Reset(Reset), .start(start_s[0]), .instructWord(iw[0]),
    .readEn(re[0]), .PC_Inc(pi[0]), .writeEn(we[0]), .instr_valid(iv[0]),
    .alu_ready(rdy[0]), .opcode(opf[0]), .rd(rdf[0]), .rs(rsf[0]), .rt(rtf[0]),
    .pc_shadow(pc[0]), .busy(busy[0]),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt(stall[0]),
`endif
    .halted(halted[0]));

  instr_fetch_ctrl #(.ADDR_W(4), .HALT_WORD(16'hFFFF), .STOP_ON_WRAP(1'b0)) u1 (
    .Clock(Clock), .Reset(Reset), .start(start_s[1]), .instructWord(iw[1]),
    .readEn(re[1]), .PC_Inc(pi[1]), .writeEn(we[1]), .instr_valid(iv[1]),
    .alu_ready(rdy[1]), .opcode(opf[1]), .rd(rdf[1]), .rs(rsf[1]), .rt(rtf[1]),
    .pc_shadow(pc[1]), .busy(busy[1]),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt(stall[1]),
`endif
    .halted(halted[1]));

  // Instruction memory model: registered read, PC advanced by PC_Inc, reset output 16'hFFFF.
  logic [15:0]     mem [16];
  logic [1:0][3:0] mpc;
  int              re_cnt [2];
  int              pi_cnt [2];

  always @(posedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        mpc[i]    <= '0;
        iw[i]     <= 16'hFFFF;
        re_cnt[i] <= 0;
        pi_cnt[i] <= 0;
      end else begin
        if (re[i]) begin
          iw[i]     <= mem[mpc[i]];
          re_cnt[i] <= re_cnt[i] + 1;
        end
        if (pi[i]) begin
          mpc[i]    <= mpc[i] + 4'd1;
          pi_cnt[i] <= pi_cnt[i] + 1;
        end
      end
    end
  end

  typedef struct packed { logic [15:0] w; logic [3:0] pc; } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   act = 0;
  int   exp_stall = 0;

  task automatic check(input bit ok, input string nm, input longint a, input longint e);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Program model: walk memory from address 0 following the issue/halt/wrap rules.
  function automatic void build_expect(input bit wrap_stop, input int limit,
                                       output bit ends_halt, output bit by_word, output int n);
    int   a = 0;
    exp_t e;
    ends_halt = 0; by_word = 0; n = 0;
    while (n < limit) begin
      if (mem[a] == 16'hFFFF) begin
        ends_halt = 1; by_word = 1;
        break;
      end
      e.w = mem[a]; e.pc = 4'(a);
      q.push_back(e);
      n++;
      if (wrap_stop && a == 15) begin
        ends_halt = 1;
        break;
      end
      a = (a + 1) % 16;
    end
  endfunction

  // Monitor: scoreboard pop on handshake, plus per-cycle protocol properties.
  initial begin
    bit          prev_iv = 0, prev_acc = 0;
    logic [15:0] prev_f = '0, cur;
    logic [3:0]  prev_pc = '0;
    exp_t        e;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        prev_iv = 0;
      end else begin
        cur = {opf[act], rdf[act], rsf[act], rtf[act]};
        check(!(re[act] && pi[act]), "strobe_overlap", {re[act], pi[act]}, 0);
        check(we[act] == 1'b0, "writeEn_zero", we[act], 0);
        if (halted[act])
          check({re[act], pi[act], busy[act]} == 3'b000, "halt_quiet",
                {re[act], pi[act], busy[act]}, 0);
        if (prev_iv && iv[act] && !prev_acc)
          check(cur == prev_f && pc[act] == prev_pc, "stall_stable",
                {cur, pc[act]}, {prev_f, prev_pc});
        if (iv[act] && !rdy[act]) exp_stall++;
        if (iv[act] && rdy[act]) begin
          if (q.size() == 0) begin
            check(0, "extra_issue", {cur, pc[act]}, 0);
          end else begin
            e = q.pop_front();
            check(cur == e.w, "issue_word", cur, e.w);
            check(pc[act] == e.pc, "issue_pc", pc[act], e.pc);
          end
        end
        prev_iv = iv[act]; prev_acc = iv[act] && rdy[act];
        prev_f = cur; prev_pc = pc[act];
      end
    end
  end

  task automatic check_reset_outputs(input int s);
    check({re[s], pi[s], we[s], iv[s], busy[s], halted[s]} == 6'b0, "rst_ctrl",
          {re[s], pi[s], we[s], iv[s], busy[s], halted[s]}, 0);
    check({opf[s], rdf[s], rsf[s], rtf[s], pc[s]} == 20'h0, "rst_data",
          {opf[s], rdf[s], rsf[s], rtf[s], pc[s]}, 0);
`ifdef FETCH_STALL_CNT_EN
    check(stall[s] == 16'h0, "rst_stall", stall[s], 0);
`endif
  endtask

  task automatic do_reset(input int cycles);
    @(posedge Clock); #1;
    Reset = 1'b1; start_s = '0; rdy = '0;
    repeat (cycles) @(posedge Clock);
    #1 Reset = 1'b0;
    exp_stall = 0;
    q.delete();
  endtask

  task automatic session(input int s, input int limit, input int ready_pct, input bit spam);
    bit ends_halt, by_word;
    int n, cyc;
    act = s;
    do_reset(1);
    build_expect(s == 0, limit, ends_halt, by_word, n);
    start_s[s] = 1'b1;
    @(posedge Clock); #1 start_s[s] = 1'b0;
    cyc = 0;
    while (!(q.size() == 0 && (!ends_halt || halted[s])) && cyc < 3000) begin
      rdy[s]     = ($urandom_range(0, 99) < ready_pct);
      start_s[s] = spam && busy[s] && ($urandom_range(0, 7) == 0);
      @(posedge Clock); #1;
      cyc++;
    end
    start_s[s] = 1'b0;
    rdy[s]     = 1'b0;
    check(cyc < 3000, "session_timeout", cyc, 3000);
    if (ends_halt) begin
      repeat (4) @(posedge Clock);
      #1;
      check(halted[s] && !busy[s], "end_halted", {halted[s], busy[s]}, 2'b10);
      check(re_cnt[s] == n + int'(by_word), "readEn_count", re_cnt[s], n + int'(by_word));
      check(pi_cnt[s] == n, "PC_Inc_count", pi_cnt[s], n);
`ifdef FETCH_STALL_CNT_EN
      check(stall[s] == 16'(exp_stall), "stall_cnt", stall[s], exp_stall);
`endif
    end else begin
      cyc = 0;
      while (!iv[s] && cyc < 20) begin
        @(posedge Clock); #1;
        cyc++;
      end
      check(iv[s], "pending_issue", iv[s], 1);
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b1;
      @(posedge Clock); #1;
      check_reset_outputs(s);
      Reset = 1'b0;
    end
  endtask

  initial begin
    act = 0;
    do_reset(3);
    check_reset_outputs(0);
    check_reset_outputs(1);

    // First-instruction latency and field split.
    for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
    mem[0] = 16'h1234;
    begin
      exp_t e;
      e.w = 16'h1234; e.pc = 4'd0;
      q.push_back(e);
    end
    rdy[0] = 1'b1;
    start_s[0] = 1'b1;
    @(posedge Clock); #1 start_s[0] = 1'b0;
    @(negedge Clock);
    check(re[0] && !pi[0], "lat_readEn", {re[0], pi[0]}, 2'b10);
    @(negedge Clock);
    check(pi[0] && !iv[0], "lat_PC_Inc", {pi[0], iv[0]}, 2'b10);
    @(negedge Clock);
    check(iv[0] && {opf[0], rdf[0], rsf[0], rtf[0]} == 16'h1234, "lat_issue",
          {iv[0], opf[0], rdf[0], rsf[0], rtf[0]}, 17'h11234);
    repeat (6) @(posedge Clock);
    #1;
    check(halted[0] && pi_cnt[0] == 1 && re_cnt[0] == 2, "lat_end",
          {halted[0], 4'(pi_cnt[0]), 4'(re_cnt[0])}, 9'h112);

    // Two issues then halt word.
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'hFFFF;
    session(0, 40, 100, 0);

    // Long stalls with start pulses while busy.
    mem[0] = 16'h0F0F; mem[1] = 16'hA5C3; mem[2] = 16'hFFFF;
    session(0, 40, 15, 1);

    // Full memory of non-halt words: stop on wrap vs. roll over to address 0.
    for (int i = 0; i < 16; i++) mem[i] = 16'(16'h1000 + i * 16'h0111);
    session(0, 40, 100, 1);
    session(1, 17, 100, 1);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++)
        mem[i] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      session(r % 2, 40, $urandom_range(30, 100), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
